// File: rtl/timestamp_uart_tx_pkg.sv
// Shared constants, FSM encoding and character-mux helper for the timestamp UART line sender.
package timestamp_uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int LINE_LEN         = 23;
    localparam int NUM_DIGITS       = 15;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Digits stored in transmit order: [0]=centenasYear ... [14]=centesimas.
    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

    function automatic logic [7:0] line_char(input logic [4:0] idx, input digits_t dg);
        logic [7:0] c;
        case (idx)
            5'd0:    c = digit_char(dg[0]);
            5'd1:    c = digit_char(dg[1]);
            5'd2:    c = digit_char(dg[2]);
            5'd3:    c = ASCII_DASH;
            5'd4:    c = digit_char(dg[3]);
            5'd5:    c = digit_char(dg[4]);
            5'd6:    c = ASCII_DASH;
            5'd7:    c = digit_char(dg[5]);
            5'd8:    c = digit_char(dg[6]);
            5'd9:    c = ASCII_SPACE;
            5'd10:   c = digit_char(dg[7]);
            5'd11:   c = digit_char(dg[8]);
            5'd12:   c = ASCII_COLON;
            5'd13:   c = digit_char(dg[9]);
            5'd14:   c = digit_char(dg[10]);
            5'd15:   c = ASCII_COLON;
            5'd16:   c = digit_char(dg[11]);
            5'd17:   c = digit_char(dg[12]);
            5'd18:   c = ASCII_DOT;
            5'd19:   c = digit_char(dg[13]);
            5'd20:   c = digit_char(dg[14]);
            5'd21:   c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/timestamp_uart_tx_byte.sv
// 8N1 byte serializer; a start seen on the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import timestamp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o,
    output logic [1:0] state_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        last;

    assign last    = (cnt_q == CNT_LAST);
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && last);
    assign tx_o    = tx_q;
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (last) begin
                    cnt_d = '0;
                    if (start_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/timestamp_uart_tx.sv
// Snapshots the calendar/stopwatch digits on send and streams them as one 23-char ASCII line.
module timestamp_uart_tx
    import timestamp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [3:0] centesimas,
    input  logic [3:0] decimas,
    input  logic [3:0] unidadesSegundo,
    input  logic [2:0] decenasSegundo,
    input  logic [3:0] unidadesMinuto,
    input  logic [3:0] decenasMinuto,
    input  logic [3:0] unidadesHora,
    input  logic [1:0] decenasHora,
    input  logic [3:0] unidadesDia,
    input  logic [1:0] decenasDia,
    input  logic [3:0] unidadesMes,
    input  logic [0:0] decenasMes,
    input  logic [3:0] unidadesYear,
    input  logic [3:0] decenasYear,
    input  logic [3:0] centenasYear,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

    digits_t    live, snap_q, snap_d;
    logic [4:0] idx_q, idx_d, sel_idx;
    logic       busy_q, busy_d, done_q, done_d;
    logic       accept, advance, finish, byte_start, byte_ready;
    logic [1:0] byte_state;
    logic [7:0] byte_data;

    always_comb begin
        live     = '0;
        live[0]  = centenasYear;
        live[1]  = decenasYear;
        live[2]  = unidadesYear;
        live[3]  = {3'b000, decenasMes};
        live[4]  = unidadesMes;
        live[5]  = {2'b00, decenasDia};
        live[6]  = unidadesDia;
        live[7]  = {2'b00, decenasHora};
        live[8]  = unidadesHora;
        live[9]  = decenasMinuto;
        live[10] = unidadesMinuto;
        live[11] = {1'b0, decenasSegundo};
        live[12] = unidadesSegundo;
        live[13] = decimas;
        live[14] = centesimas;
    end

    // done_q blocks acceptance so a send coincident with done is dropped.
    assign accept     = send && !busy_q && !done_q && (byte_state == ST_IDLE);
    assign advance    = busy_q && byte_ready && (idx_q != LAST_IDX);
    assign finish     = busy_q && byte_ready && (idx_q == LAST_IDX);
    assign byte_start = accept || advance;

    // Char 0 leaves on the accept edge, so it comes straight from the live inputs.
    assign sel_idx   = busy_q ? (idx_q + 5'd1) : 5'd0;
    assign byte_data = line_char(sel_idx, busy_q ? snap_q : live);

    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = finish;
        if (accept) begin
            snap_d = live;
            idx_d  = 5'd0;
            busy_d = 1'b1;
        end
        if (advance) idx_d  = idx_q + 5'd1;
        if (finish)  busy_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            idx_q  <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (byte_start),
        .data_i  (byte_data),
        .tx_o    (tx),
        .ready_o (byte_ready),
        .state_o (byte_state)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/timestamp_uart_tx.md
# timestamp_uart_tx

Serializer for the calendar/stopwatch digit chain. On a `send` pulse it takes one coherent snapshot of every BCD digit register (hundredths through hundreds-of-year) and transmits it as a 23-character ASCII line over a UART 8N1 output. It is the read-out end of the digit counters, feeding a PC terminal or logger.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `send`  in  1  request; sampled only in IDLE
- `centesimas`  in  4  hundredths digit
- `decimas`  in  4  tenths digit
- `unidadesSegundo` in 4, `decenasSegundo` in 3  seconds digits
- `unidadesMinuto` in 4, `decenasMinuto` in 4  minutes digits
- `unidadesHora` in 4, `decenasHora` in 2  hours digits
- `unidadesDia` in 4, `decenasDia` in 2  day digits
- `unidadesMes` in 4, `decenasMes` in 1  month digits
- `unidadesYear`, `decenasYear`, `centenasYear`  in  4 each  year digits
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a line is in flight
- `done`  out  1  one-cycle pulse when the final stop bit completes

## Operation
- Line format, in transmit order (23 chars): centenasYear, decenasYear, unidadesYear, '-', decenasMes, unidadesMes, '-', decenasDia, unidadesDia, ' ', decenasHora, unidadesHora, ':', decenasMinuto, unidadesMinuto, ':', decenasSegundo, unidadesSegundo, '.', decimas, centesimas, CR (0x0D), LF (0x0A).
- Digit encoding: zero-extend to 4 bits, char = 0x30 + digit. No clamping: a value above 9 is sent as 0x30+value (e.g. 10 → ':'). Digits are sent as stored; no month remapping.
- Snapshot: all 15 digits latched on the edge where `send`=1 in IDLE. Input changes afterwards have no effect on the line in flight.
- FSM: IDLE → START (tx=0) → DATA (8 bits, LSB first) → STOP (tx=1) → START of next char, or IDLE after char 22. No idle gap between characters.
- Counters: baud counter 0..CLKS_PER_BIT-1; bit index 0..7; char index 0..22.
- `send` during `busy` is ignored (not queued). `send` in the same cycle as `done` is also ignored; it is accepted from the next cycle.
- Reset (any time, including mid-frame): tx=1, busy=0, done=0, state IDLE, all counters 0, snapshot cleared to 0. Takes effect immediately (asynchronous).

## Timing
- `send` accepted at edge T0: `busy`=1 and `tx`=0 (start bit of char 0) from T0. Registered outputs, no combinational path from `send` to `tx`.
- Each bit lasts exactly CLKS_PER_BIT cycles; each char 10 bits.
- Last stop bit ends at T0 + 230·CLKS_PER_BIT. At that edge: `busy`→0, `done`=1 for one cycle, `tx` stays 1.
- Next `send` accepted at the earliest one cycle after `done`.

## Structure
- Shared package: ASCII constants (dash, space, colon, dot, CR, LF, '0' base), `LINE_LEN`=23, FSM state enum, `CLKS_PER_BIT` default.
- One sub-module, `uart_tx_byte`: 8N1 byte serializer with `start`/`ready`, owning the baud and bit counters. The top level owns the snapshot, char index and the mux that selects the character.

## Test plan (CLKS_PER_BIT=4)
- After reset, all digits 0, pulse `send` → line "000-00-00 00:00:00.00\r\n"; `done` exactly 920 cycles after acceptance.
- Digits 1,9,8 / 1,1 / 2,5 / 2,3 / 5,9 / 5,9 / 9,9 → decoded line "198-11-25 23:59:59.99\r\n". Each bit is 4 cycles wide, LSB first, stop bits high.
- Change every digit input to 0 at cycle 50 of a line → transmitted line is unchanged (snapshot held).
- Pulse `send` at cycles 10, 400 and 919 after acceptance → exactly one line sent; `send` at done+1 starts a new line.
- Assert `rst` at cycle 300 of a line → `tx`=1, `busy`=0 in the same cycle; no `done`. A `send` after reset release transmits a full line.
- Set decimas=10, decenasSegundo=7 → chars ':' and '7' in the tenths and tens-of-seconds positions.
